// File: rtl/alu_rs_scheduler_pkg.sv
// Shared CPU types for the ALU reservation-station scheduler.
package alu_rs_scheduler_pkg;

    localparam int unsigned RS_SIZE_DEFAULT   = 4;
    localparam int unsigned CDB_PORTS_DEFAULT = 2;
    localparam int unsigned ROB_SIZE          = 16;
    localparam int unsigned DATA_W            = 32;
    localparam int unsigned OP_W              = 4;

    typedef logic [$clog2(RS_SIZE_DEFAULT)-1:0] rs_index_t;
    typedef logic [$clog2(ROB_SIZE)-1:0]        rob_index_t;
    typedef logic [DATA_W-1:0]                  uint32_t;
    typedef logic [OP_W-1:0]                    alu_op_t;

    // One reservation-station payload: two source operands, destination tag, opcode.
    typedef struct packed {
        logic [1:0]       operand_ready;
        rob_index_t [1:0] operand_addr;
        uint32_t [1:0]    operand_data;
        rob_index_t       reorder;
        alu_op_t          op;
    } reserve_station_t;

endpackage

// File: rtl/alu_rs_scheduler_if.sv
// Issue-stage / CDB / ALU-side bundle for the ALU reservation station.
interface alu_rs_scheduler_if #(
    parameter int unsigned RS_SIZE   = alu_rs_scheduler_pkg::RS_SIZE_DEFAULT,
    parameter int unsigned CDB_PORTS = alu_rs_scheduler_pkg::CDB_PORTS_DEFAULT
);
    import alu_rs_scheduler_pkg::*;

    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    logic [1:0]                  alu_ready;
    logic [1:0][IDX_W-1:0]       alu_index;
    logic [1:0]                  wr_en;
    logic [1:0][IDX_W-1:0]       wr_index;
    reserve_station_t [1:0]      wr_entry;
    logic [CDB_PORTS-1:0]        cdb_valid;
    rob_index_t [CDB_PORTS-1:0]  cdb_reorder;
    uint32_t [CDB_PORTS-1:0]     cdb_value;
    logic                        issue_valid;
    reserve_station_t            issue_entry;
    logic                        fu_ready;
    logic                        flush;

    modport master (
        input  alu_ready, alu_index, issue_valid, issue_entry,
        output wr_en, wr_index, wr_entry, cdb_valid, cdb_reorder, cdb_value,
               fu_ready, flush
    );

    modport slave (
        output alu_ready, alu_index, issue_valid, issue_entry,
        input  wr_en, wr_index, wr_entry, cdb_valid, cdb_reorder, cdb_value,
               fu_ready, flush
    );

endinterface

// File: rtl/alu_rs_scheduler_age.sv
// rs_age_matrix: oldest-first arbitration over the reservation-station entries.
// Only compiled when ALU_RS_AGE_SELECT_EN is defined; age[i][j]=1 means j is older than i.
`ifdef ALU_RS_AGE_SELECT_EN
module rs_age_matrix #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [N-1:0] occupied,
    input  logic [N-1:0] alloc0,
    input  logic [N-1:0] alloc1,
    input  logic [N-1:0] free,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    logic [N-1:0][N-1:0] age;
    logic [N-1:0][N-1:0] age_nxt;

    // Allocation marks every surviving entry (and a same-cycle port-0 write) as older.
    always_comb begin
        age_nxt = age;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (free[j]) age_nxt[i][j] = 1'b0;
                if (alloc0[i]) age_nxt[i][j] = occupied[j] & ~free[j];
                if (alloc1[i]) age_nxt[i][j] = (occupied[j] & ~free[j]) | alloc0[j];
            end
            age_nxt[i][i] = 1'b0;
        end
        if (flush) age_nxt = '0;
    end

    // Age state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) age <= '0;
        else     age <= age_nxt;
    end

    // A requester wins when no older entry is also requesting.
    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < N; i++) begin
            grant[i] = req[i] & ~(|(age[i] & req));
        end
    end

endmodule
`endif

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: dual-port allocate, CDB wakeup with write bypass, single issue.
// Optional macro ALU_RS_AGE_SELECT_EN selects oldest-ready instead of lowest-index-ready.
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int unsigned RS_SIZE   = RS_SIZE_DEFAULT,
    parameter int unsigned CDB_PORTS = CDB_PORTS_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    alu_rs_scheduler_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]             valid;
    logic [RS_SIZE-1:0]             valid_nxt;
    reserve_station_t [RS_SIZE-1:0] entries;
    reserve_station_t [RS_SIZE-1:0] entries_nxt;
    logic [RS_SIZE-1:0]             ready;
    logic [RS_SIZE-1:0]             grant;
    logic [RS_SIZE-1:0]             free_vec;
    logic [IDX_W-1:0]               sel_idx;
    logic [1:0]                     free_ok;
    logic [1:0][IDX_W-1:0]          free_idx;
    logic                           issue_fire;

    // Capture matching CDB values into not-ready operands; lowest port wins on duplicates.
    function automatic reserve_station_t wakeup(
        input reserve_station_t           e,
        input logic [CDB_PORTS-1:0]       cv,
        input rob_index_t [CDB_PORTS-1:0] ct,
        input uint32_t [CDB_PORTS-1:0]    cd
    );
        reserve_station_t r;
        logic             hit;
        r = e;
        for (int unsigned k = 0; k < 2; k++) begin
            hit = 1'b0;
            for (int unsigned p = 0; p < CDB_PORTS; p++) begin
                if (!e.operand_ready[k] && !hit && cv[p] && (ct[p] == e.operand_addr[k])) begin
                    r.operand_ready[k] = 1'b1;
                    r.operand_data[k]  = cd[p];
                    hit                = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Lowest and second-lowest free slots from registered valid bits only.
    always_comb begin
        free_ok  = '0;
        free_idx = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!valid[i]) begin
                if (!free_ok[0]) begin
                    free_idx[0] = IDX_W'(i);
                    free_ok[0]  = 1'b1;
                end else if (!free_ok[1]) begin
                    free_idx[1] = IDX_W'(i);
                    free_ok[1]  = 1'b1;
                end
            end
        end
    end

    assign bus.alu_ready = free_ok;
    assign bus.alu_index = free_idx;

    // Entry is issuable once both operands are present.
    always_comb begin
        ready = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            ready[i] = valid[i] & (&entries[i].operand_ready);
        end
    end

    assign issue_fire = (|ready) & bus.fu_ready;
    assign free_vec   = issue_fire ? grant : '0;

`ifdef ALU_RS_AGE_SELECT_EN
    logic [RS_SIZE-1:0] alloc0;
    logic [RS_SIZE-1:0] alloc1;

    // One-hot allocation vectors per write port.
    always_comb begin
        alloc0 = '0;
        alloc1 = '0;
        if (bus.wr_en[0]) alloc0[bus.wr_index[0]] = 1'b1;
        if (bus.wr_en[1]) alloc1[bus.wr_index[1]] = 1'b1;
    end

    rs_age_matrix #(.N(RS_SIZE)) u_age (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .occupied (valid),
        .alloc0   (alloc0),
        .alloc1   (alloc1),
        .free     (free_vec),
        .req      (ready),
        .grant    (grant)
    );
`else
    // Fixed priority: lowest-index ready entry.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

    // Encode the one-hot grant for the read mux.
    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (grant[i]) sel_idx = IDX_W'(i);
        end
    end

    assign bus.issue_valid = |ready;
    assign bus.issue_entry = entries[sel_idx];

    // Next state: wakeup, issue release, allocation with bypass; flush overrides all.
    always_comb begin
        valid_nxt   = valid;
        entries_nxt = entries;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (valid[i]) begin
                entries_nxt[i] = wakeup(entries[i], bus.cdb_valid, bus.cdb_reorder, bus.cdb_value);
            end
            if (free_vec[i]) valid_nxt[i] = 1'b0;
        end
        for (int unsigned w = 0; w < 2; w++) begin
            if (bus.wr_en[w]) begin
                entries_nxt[bus.wr_index[w]] = wakeup(bus.wr_entry[w], bus.cdb_valid,
                                                      bus.cdb_reorder, bus.cdb_value);
                valid_nxt[bus.wr_index[w]]   = 1'b1;
            end
        end
        if (bus.flush) valid_nxt = '0;
    end

    // Entry storage and valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= '0;
            entries <= '0;
        end else begin
            valid   <= valid_nxt;
            entries <= entries_nxt;
        end
    end

    a_dual_write_same_index: assert property (@(posedge clk) disable iff (rst)
        !((&bus.wr_en) && (bus.wr_index[0] == bus.wr_index[1])));

    a_write_when_full: assert property (@(posedge clk) disable iff (rst)
        !((free_ok == 2'b00) && (|bus.wr_en)));

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: directed scenarios then randomized traffic vs a slot-level model.
module tb_alu_rs_scheduler;
    import alu_rs_scheduler_pkg::*;

    localparam int RS = RS_SIZE_DEFAULT;
    localparam int CP = CDB_PORTS_DEFAULT;

    typedef struct {
        bit               v;
        reserve_station_t e;
        int               seq;
    } ment_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   seq_ctr = 0;
    ment_t m[RS];

    alu_rs_scheduler_if bus ();

    alu_rs_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic reserve_station_t mk(input logic [1:0] rdy, input int a0, input int a1,
                                            input logic [31:0] d0, input logic [31:0] d1,
                                            input int rob);
        reserve_station_t e;
        e.operand_ready   = rdy;
        e.operand_addr[0] = rob_index_t'(a0);
        e.operand_addr[1] = rob_index_t'(a1);
        e.operand_data[0] = d0;
        e.operand_data[1] = d1;
        e.reorder         = rob_index_t'(rob);
        e.op              = alu_op_t'(rob);
        return e;
    endfunction

    // Operands still waiting take the value of the first valid CDB port carrying their tag.
    function automatic reserve_station_t m_wake(input reserve_station_t e);
        reserve_station_t r;
        r = e;
        for (int k = 0; k < 2; k++) begin
            if (!e.operand_ready[k]) begin
                for (int p = 0; p < CP; p++) begin
                    if (bus.cdb_valid[p] && bus.cdb_reorder[p] == e.operand_addr[k]) begin
                        r.operand_ready[k] = 1'b1;
                        r.operand_data[k]  = bus.cdb_value[p];
                        break;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic int model_sel();
        int best;
        best = -1;
        for (int i = 0; i < RS; i++) begin
            if (m[i].v && m[i].e.operand_ready == 2'b11) begin
`ifdef ALU_RS_AGE_SELECT_EN
                if (best < 0 || m[i].seq < m[best].seq) best = i;
`else
                if (best < 0) best = i;
`endif
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS; i++) begin
            m[i].v   = 1'b0;
            m[i].e   = '0;
            m[i].seq = 0;
        end
        seq_ctr = 0;
    endtask

    task automatic model_update(input int sel);
        ment_t nm[RS];
        nm = m;
        if (bus.flush) begin
            for (int i = 0; i < RS; i++) nm[i].v = 1'b0;
        end else begin
            for (int i = 0; i < RS; i++) if (m[i].v) nm[i].e = m_wake(m[i].e);
            if (sel >= 0 && bus.fu_ready) nm[sel].v = 1'b0;
            for (int w = 0; w < 2; w++) begin
                if (bus.wr_en[w]) begin
                    nm[int'(bus.wr_index[w])].v   = 1'b1;
                    nm[int'(bus.wr_index[w])].e   = m_wake(bus.wr_entry[w]);
                    nm[int'(bus.wr_index[w])].seq = seq_ctr;
                    seq_ctr++;
                end
            end
        end
        m = nm;
    endtask

    // Check outputs mid-cycle against the model, advance one clock, clear one-shot inputs.
    task automatic step();
        int sel;
        int fq[$];
        logic [1:0] er;
        @(negedge clk);
        fq = {};
        for (int i = 0; i < RS; i++) if (!m[i].v) fq.push_back(i);
        er = {fq.size() >= 2, fq.size() >= 1};
        check("alu_ready", 128'(bus.alu_ready), 128'(er));
        if (er[0]) check("alu_index0", 128'(bus.alu_index[0]), 128'(fq[0]));
        if (er[1]) check("alu_index1", 128'(bus.alu_index[1]), 128'(fq[1]));
        sel = model_sel();
        check("issue_valid", 128'(bus.issue_valid), 128'(sel >= 0));
        if (sel >= 0) check("issue_entry", 128'(bus.issue_entry), 128'(m[sel].e));
        model_update(sel);
        @(posedge clk);
        #1;
        bus.wr_en     = '0;
        bus.cdb_valid = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic put(input int port, input int idx, input reserve_station_t e);
        bus.wr_en[port]    = 1'b1;
        bus.wr_index[port] = rs_index_t'(idx);
        bus.wr_entry[port] = e;
    endtask

    task automatic bcast(input int port, input int tag, input logic [31:0] val);
        bus.cdb_valid[port]   = 1'b1;
        bus.cdb_reorder[port] = rob_index_t'(tag);
        bus.cdb_value[port]   = val;
    endtask

    task automatic drain(input int n);
        bus.fu_ready = 1'b1;
        repeat (n) step();
        bus.fu_ready = 1'b0;
    endtask

    initial begin
        bus.wr_en       = '0;
        bus.wr_index    = '0;
        bus.wr_entry    = '0;
        bus.cdb_valid   = '0;
        bus.cdb_reorder = '0;
        bus.cdb_value   = '0;
        bus.fu_ready    = 1'b0;
        bus.flush       = 1'b0;
        model_reset();

        // Reset values
        #1;
        check("rst_alu_ready", 128'(bus.alu_ready), 128'(2'b11));
        check("rst_alu_index0", 128'(bus.alu_index[0]), 128'(0));
        check("rst_alu_index1", 128'(bus.alu_index[1]), 128'(1));
        check("rst_issue_valid", 128'(bus.issue_valid), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step();

        // Two ready entries: 0 issues before 1
        put(0, 0, mk(2'b11, 0, 0, 32'h11, 32'h22, 1));
        put(1, 1, mk(2'b11, 0, 0, 32'h33, 32'h44, 2));
        step();
        check("t1_valid", 128'(bus.issue_valid), 128'(1));
        check("t1_first", 128'(bus.issue_entry.reorder), 128'(1));
        bus.fu_ready = 1'b1;
        step();
        check("t1_second", 128'(bus.issue_entry.reorder), 128'(2));
        step();
        bus.fu_ready = 1'b0;
        step();

        // Wakeup of a waiting operand
        put(0, 2, mk(2'b01, 0, 5, 32'hA, 32'h0, 3));
        step();
        bcast(0, 5, 32'hDEADBEEF);
        step();
        check("t2_valid", 128'(bus.issue_valid), 128'(1));
        check("t2_data", 128'(bus.issue_entry.operand_data[1]), 128'(32'hDEADBEEF));
        drain(1);

        // Write bypass from a same-cycle broadcast
        put(0, 0, mk(2'b10, 7, 0, 32'h0, 32'd111, 4));
        bcast(0, 7, 32'h12345678);
        step();
        check("t3_valid", 128'(bus.issue_valid), 128'(1));
        check("t3_data", 128'(bus.issue_entry.operand_data[0]), 128'(32'h12345678));
        drain(1);

        // Full, then one issue frees exactly one slot
        put(0, 0, mk(2'b11, 0, 0, 32'h1, 32'h2, 5));
        put(1, 1, mk(2'b11, 0, 0, 32'h3, 32'h4, 6));
        step();
        put(0, 2, mk(2'b11, 0, 0, 32'h5, 32'h6, 7));
        put(1, 3, mk(2'b11, 0, 0, 32'h7, 32'h8, 8));
        step();
        check("t4_full", 128'(bus.alu_ready), 128'(2'b00));
        drain(1);
        check("t4_one_free", 128'(bus.alu_ready), 128'(2'b01));
        check("t4_free_idx", 128'(bus.alu_index[0]), 128'(0));
        drain(3);
        step();

        // Age vs index priority
        put(0, 3, mk(2'b11, 0, 0, 32'h9, 32'h9, 9));
        step();
        put(0, 0, mk(2'b11, 0, 0, 32'hA, 32'hA, 10));
        step();
`ifdef ALU_RS_AGE_SELECT_EN
        check("t5_pick", 128'(bus.issue_entry.reorder), 128'(9));
`else
        check("t5_pick", 128'(bus.issue_entry.reorder), 128'(10));
`endif
        drain(2);

        // Flush beats write, wakeup and issue
        put(0, 0, mk(2'b11, 0, 0, 32'h1, 32'h1, 11));
        put(1, 1, mk(2'b01, 0, 4, 32'h1, 32'h1, 12));
        step();
        put(0, 2, mk(2'b10, 4, 0, 32'h0, 32'h1, 13));
        bcast(0, 4, 32'h55);
        bus.flush    = 1'b1;
        bus.fu_ready = 1'b1;
        step();
        bus.fu_ready = 1'b0;
        check("t6_issue_valid", 128'(bus.issue_valid), 128'(0));
        check("t6_alu_ready", 128'(bus.alu_ready), 128'(2'b11));
        step();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            int fq[$];
            int nw;
            int k;
            reserve_station_t e;
            fq = {};
            for (int i = 0; i < RS; i++) if (!m[i].v) fq.push_back(i);
            nw = $urandom_range(0, 2);
            if (nw > fq.size()) nw = fq.size();
            for (int w = 0; w < nw; w++) begin
                k = $urandom_range(0, fq.size() - 1);
                e = mk(2'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom, $urandom, $urandom_range(0, 15));
                put(w, fq[k], e);
                fq.delete(k);
            end
            for (int p = 0; p < CP; p++) begin
                if ($urandom_range(0, 1) == 1) bcast(p, $urandom_range(0, 7), $urandom);
            end
            if (bus.cdb_valid[0] && $urandom_range(0, 3) == 0) bcast(1, int'(bus.cdb_reorder[0]), $urandom);
            bus.fu_ready = ($urandom_range(0, 3) != 0);
            bus.flush    = ($urandom_range(0, 49) == 0);
            step();
        end
        bus.fu_ready = 1'b0;

        // Reset in the middle of operation discards everything at once
        put(0, int'(bus.alu_index[0]), mk(2'b11, 0, 0, 32'h77, 32'h88, 14));
        step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("mid_rst_issue_valid", 128'(bus.issue_valid), 128'(0));
        check("mid_rst_alu_ready", 128'(bus.alu_ready), 128'(2'b11));
        check("mid_rst_alu_index0", 128'(bus.alu_index[0]), 128'(0));
        check("mid_rst_alu_index1", 128'(bus.alu_index[1]), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
